// File: rtl/mux_21_arbiter.sv
// Two-requester round-robin arbiter driving the shared 2:1 mux select and registered data.
// Optional hold-limit timeout enabled by defining MUX21_ARB_TIMEOUT_EN.
module mux_21_arbiter #(
    parameter int W        = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [1:0]     REQ,
    input  logic [2*W-1:0] A,
    output logic           S,
    output logic [1:0]     GNT,
    output logic [W-1:0]   Q,
    output logic           VALID
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t state, next_state;
    logic   last;
    logic   force_handover;

    generate
        if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
            $error("mux_21_arbiter: MAX_HOLD must be in 1..255");
        end
    endgenerate

`ifdef MUX21_ARB_TIMEOUT_EN
    logic [7:0] hcnt;
    logic       hold_max;

    assign hold_max       = (hcnt == 8'(MAX_HOLD - 1));
    assign force_handover = hold_max && (REQ == 2'b11);

    // Counts consecutive cycles in the current grant; saturates when nobody else waits.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hcnt <= '0;
        end else if (next_state != state) begin
            hcnt <= '0;
        end else if (state != IDLE && !hold_max) begin
            hcnt <= hcnt + 8'd1;
        end
    end
`else
    assign force_handover = 1'b0;
`endif

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                unique case (REQ)
                    2'b01:   next_state = G0;
                    2'b10:   next_state = G1;
                    2'b11:   next_state = last ? G0 : G1;
                    default: next_state = IDLE;
                endcase
            end
            G0: begin
                if (!REQ[0])
                    next_state = REQ[1] ? G1 : IDLE;
                else if (force_handover)
                    next_state = G1;
            end
            G1: begin
                if (!REQ[1])
                    next_state = REQ[0] ? G0 : IDLE;
                else if (force_handover)
                    next_state = G0;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            last  <= 1'b1;
            S     <= 1'b0;
            Q     <= '0;
            VALID <= 1'b0;
        end else begin
            state <= next_state;
            // Select and round-robin pointer follow the grant; both hold through IDLE.
            if (next_state == G0) begin
                last <= 1'b0;
                S    <= 1'b0;
            end else if (next_state == G1) begin
                last <= 1'b1;
                S    <= 1'b1;
            end
            unique case (state)
                G0: begin
                    Q     <= A[W-1:0];
                    VALID <= 1'b1;
                end
                G1: begin
                    Q     <= A[2*W-1:W];
                    VALID <= 1'b1;
                end
                default: begin
                    Q     <= '0;
                    VALID <= 1'b0;
                end
            endcase
        end
    end

    assign GNT = {state == G1, state == G0};

endmodule
